fabric_line_responder: RTL and testbench

//  Memory-side responder on the fabric data bus: the target that code loaders address and burst
//  4-word L1 lines into/out of. Holds DEPTH words; accepts ADDRFD/WRITEFD/READFD strobes from the
//  bus-owning master, reports BUSY_line_SLAVE, drives read beats with its own output enable.

---
 rtl/fabric_line_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_fabric_line_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_line_responder.sv
// fabric_line_responder
//   Memory-side target on the fabric data bus. A bus-owning master sets a line address with
//   ADDRFD, then either bursts four words in with WRITEFD beats or requests a four-word read
//   burst with READFD. The responder holds 2**ADDR_W words organised as 4-word lines.
//
// Ports
//   CLK_B             clock, all logic on the rising edge
//   RESET             synchronous active-low reset
//   FD_IN             bus lanes {D3,D2,D1,D0}; D0 carries the address, low WORD_W bits the data
//   FD_OUT            read beat data, zero-extended, forced to 0 when FD_OE is low
//   FD_OE             responder drives the bus (read beats only)
//   FD_VALID          FD_OUT holds a valid read beat
//   ADDRFD            address strobe
//   WRITEFD           write beat strobe
//   READFD            read burst request
//   BUSY_line_MASTER  a granted master owns the bus; strobes are only sampled while high
//   BUSY_line_SLAVE   responder is committing or reading and cannot accept strobes
//   ERR_CNT           saturating protocol-error counter
module fabric_line_responder #(
    parameter int unsigned SEG_W  = 8,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WR_LAT = 1,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                 CLK_B,
    input  logic                 RESET,
    input  logic [4*SEG_W-1:0]   FD_IN,
    output logic [4*SEG_W-1:0]   FD_OUT,
    output logic                 FD_OE,
    output logic                 FD_VALID,
    input  logic                 ADDRFD,
    input  logic                 WRITEFD,
    input  logic                 READFD,
    input  logic                 BUSY_line_MASTER,
    output logic                 BUSY_line_SLAVE,
    output logic [7:0]           ERR_CNT
);

    localparam int unsigned Depth  = 2 ** ADDR_W;
    localparam int unsigned MaxLat = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int unsigned LatW   = $clog2(MaxLat + 1);

    typedef enum logic [2:0] {StIdle, StWBurst, StWCommit, StRWait, StRStream} state_e;

    state_e              state_q, state_d;
    logic                addr_ok_q, addr_ok_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          beat_q, beat_d;
    logic [LatW-1:0]     lat_q, lat_d;
    logic [WORD_W-1:0]   stage_q [4];
    logic [WORD_W-1:0]   stage_d [4];
    logic [7:0]          err_cnt_q;
    logic                err_ev;
    logic                commit;
    logic [WORD_W-1:0]   mem_q [Depth];

    logic any_strobe;
    logic multi_strobe;
    logic unused_fd;

    assign any_strobe   = ADDRFD | WRITEFD | READFD;
    assign multi_strobe = (ADDRFD & WRITEFD) | (ADDRFD & READFD) | (WRITEFD & READFD);
    // Upper lanes are never decoded; only part of FD_IN reaches the logic.
    assign unused_fd    = ^FD_IN;

    always_comb begin
        state_d   = state_q;
        addr_ok_d = addr_ok_q;
        base_d    = base_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        stage_d   = stage_q;
        err_ev    = 1'b0;
        commit    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (BUSY_line_MASTER) begin
                    if (multi_strobe) begin
                        err_ev = 1'b1;
                    end else if (ADDRFD) begin
                        // Line aligned: the two low address bits select the beat, not the line.
                        base_d    = {FD_IN[ADDR_W-1:2], 2'b00};
                        addr_ok_d = 1'b1;
                    end else if (WRITEFD) begin
                        if (!addr_ok_q) begin
                            err_ev = 1'b1;
                        end else begin
                            stage_d[0] = FD_IN[WORD_W-1:0];
                            beat_d     = 2'd1;
                            state_d    = StWBurst;
                        end
                    end else if (READFD) begin
                        if (!addr_ok_q) begin
                            err_ev = 1'b1;
                        end else begin
                            lat_d   = '0;
                            state_d = StRWait;
                        end
                    end
                end
            end

            StWBurst: begin
                if (!BUSY_line_MASTER) begin
                    err_ev    = 1'b1;
                    addr_ok_d = 1'b0;
                    beat_d    = 2'd0;
                    state_d   = StIdle;
                end else begin
                    if (ADDRFD || READFD) begin
                        err_ev = 1'b1;
                    end
                    if (WRITEFD) begin
                        stage_d[beat_q] = FD_IN[WORD_W-1:0];
                        beat_d          = beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            lat_d   = '0;
                            state_d = StWCommit;
                        end
                    end
                end
            end

            StWCommit: begin
                // Losing the bus here does not abort: the line is already fully staged.
                if (BUSY_line_MASTER && any_strobe) begin
                    err_ev = 1'b1;
                end
                if (lat_q == LatW'(WR_LAT - 1)) begin
                    commit    = 1'b1;
                    addr_ok_d = 1'b0;
                    beat_d    = 2'd0;
                    state_d   = StIdle;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end

            StRWait: begin
                if (!BUSY_line_MASTER) begin
                    err_ev    = 1'b1;
                    addr_ok_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    if (any_strobe) begin
                        err_ev = 1'b1;
                    end
                    if (lat_q == LatW'(RD_LAT - 1)) begin
                        beat_d  = 2'd0;
                        state_d = StRStream;
                    end else begin
                        lat_d = lat_q + LatW'(1);
                    end
                end
            end

            StRStream: begin
                if (!BUSY_line_MASTER) begin
                    err_ev    = 1'b1;
                    addr_ok_d = 1'b0;
                    beat_d    = 2'd0;
                    state_d   = StIdle;
                end else begin
                    if (any_strobe) begin
                        err_ev = 1'b1;
                    end
                    if (beat_q == 2'd3) begin
                        addr_ok_d = 1'b0;
                        beat_d    = 2'd0;
                        state_d   = StIdle;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK_B) begin
        if (!RESET) begin
            state_q   <= StIdle;
            addr_ok_q <= 1'b0;
            base_q    <= '0;
            beat_q    <= 2'd0;
            lat_q     <= '0;
            err_cnt_q <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_ok_q <= addr_ok_d;
            base_q    <= base_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            stage_q   <= stage_d;
            if (err_ev && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Storage is not reset; a reset edge blocks a pending commit.
    always_ff @(posedge CLK_B) begin
        if (RESET && commit) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[base_q | ADDR_W'(i)] <= stage_q[i];
            end
        end
    end

    always_comb begin
        FD_OUT          = '0;
        FD_OE           = (state_q == StRStream);
        FD_VALID        = (state_q == StRStream);
        BUSY_line_SLAVE = (state_q == StWCommit) || (state_q == StRWait) ||
                          (state_q == StRStream);
        if (state_q == StRStream) begin
            FD_OUT[WORD_W-1:0] = mem_q[base_q | ADDR_W'(beat_q)];
        end
    end

    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_fabric_line_responder.sv
// Bench for fabric_line_responder: table of line write/read-back vectors plus hand-written
// sequences for aborts, protocol errors, reset during commit and error-counter saturation.
// Read beats are predicted into a queue when READFD is issued and popped by a monitor.
module tb_fabric_line_responder;

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned WR_LAT = 1;
    localparam int unsigned RD_LAT = 2;

    logic        clk_b;
    logic        reset;
    logic [31:0] fd_in;
    logic [31:0] fd_out;
    logic        fd_oe;
    logic        fd_valid;
    logic        addrfd;
    logic        writefd;
    logic        readfd;
    logic        master;
    logic        slave_busy;
    logic [7:0]  err_cnt;

    fabric_line_responder #(
        .SEG_W  (SEG_W),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .WR_LAT (WR_LAT),
        .RD_LAT (RD_LAT)
    ) dut (
        .CLK_B            (clk_b),
        .RESET            (reset),
        .FD_IN            (fd_in),
        .FD_OUT           (fd_out),
        .FD_OE            (fd_oe),
        .FD_VALID         (fd_valid),
        .ADDRFD           (addrfd),
        .WRITEFD          (writefd),
        .READFD           (readfd),
        .BUSY_line_MASTER (master),
        .BUSY_line_SLAVE  (slave_busy),
        .ERR_CNT          (err_cnt)
    );

    initial clk_b = 1'b0;
    always #5 clk_b = ~clk_b;

    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_q [$];
    logic [15:0] mem_m [64];
    int          exp_err = 0;

    typedef struct packed {
        logic [7:0]       addr;
        logic [3:0][15:0] d;
        logic [7:0]       gap;
        logic [7:0]       base;
    } vec_t;

    vec_t vt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_b);
        #1;
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    // Read beats are checked mid-cycle, away from the active edge.
    always @(negedge clk_b) begin
        if (mon_en) begin
            if (fd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_extra: got 0x%0h, required no beat at %0t", fd_out, $time);
                end else begin
                    chk("read_beat", fd_out, exp_q.pop_front());
                    chk("beat_oe", {31'b0, fd_oe}, 32'd1);
                end
            end else if (fd_oe === 1'b0) begin
                chk("out_idle_zero", fd_out, 32'd0);
            end
        end
    end

    task automatic do_write(input logic [7:0] a, input logic [3:0][15:0] d, input int gap);
        step();
        addrfd = 1'b1;
        fd_in  = {24'hABCDEF, a};
        step();
        addrfd = 1'b0;
        fd_in  = 32'd0;
        for (int b = 0; b < 4; b++) begin
            writefd = 1'b1;
            fd_in   = {16'hDEAD, d[b]};
            step();
            writefd = 1'b0;
            fd_in   = 32'd0;
            if (b < 3) begin
                chk("wburst_not_busy", {31'b0, slave_busy}, 32'd0);
                repeat (gap) step();
            end
        end
        for (int k = 1; k <= int'(WR_LAT) + 1; k++) begin
            chk("wr_busy", {31'b0, slave_busy}, {31'b0, (k <= int'(WR_LAT))});
            if (k <= int'(WR_LAT)) step();
        end
    endtask

    // abort_k: cycle after READFD in which the master drops the bus (0 = no abort).
    task automatic do_read(input logic [7:0] a, input logic [5:0] base, input int abort_k);
        int end_k;
        int nbeats;
        end_k  = (abort_k != 0) ? abort_k : int'(RD_LAT) + 4;
        nbeats = end_k - int'(RD_LAT);
        step();
        addrfd = 1'b1;
        fd_in  = {24'h5A5A5A, a};
        step();
        addrfd = 1'b0;
        fd_in  = 32'd0;
        readfd = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            exp_q.push_back({16'h0, mem_m[base | 6'(i)]});
        end
        step();
        readfd = 1'b0;
        for (int k = 1; k <= int'(RD_LAT) + 5; k++) begin
            chk("rd_busy", {31'b0, slave_busy}, {31'b0, (k <= end_k)});
            chk("rd_oe", {31'b0, fd_oe}, {31'b0, (k > int'(RD_LAT) && k <= end_k)});
            if (abort_k != 0 && k == abort_k) master = 1'b0;
            if (abort_k != 0 && k == abort_k + 1) master = 1'b1;
            step();
        end
        chk("rd_beats_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        if (abort_k != 0) bump_err();
        chk("rd_err_cnt", {24'b0, err_cnt}, exp_err);
    endtask

    initial begin
        vt[0] = '{addr: 8'h09, d: {16'h4444, 16'h3333, 16'h2222, 16'h1111}, gap: 8'd0,
                  base: 8'h08};
        vt[1] = '{addr: 8'hFF, d: {16'hA3A3, 16'hA2A2, 16'hA1A1, 16'hA0A0}, gap: 8'd0,
                  base: 8'h3C};
        vt[2] = '{addr: 8'hE2, d: {16'h0C0D, 16'h0A0B, 16'h0809, 16'h0607}, gap: 8'd1,
                  base: 8'h20};
        vt[3] = '{addr: 8'h13, d: {16'h7777, 16'h6666, 16'h5555, 16'hFEED}, gap: 8'd3,
                  base: 8'h10};

        reset   = 1'b0;
        master  = 1'b1;
        addrfd  = 1'b0;
        writefd = 1'b0;
        readfd  = 1'b0;
        fd_in   = 32'd0;
        repeat (3) step();
        chk("reset_oe", {31'b0, fd_oe}, 32'd0);
        chk("reset_valid", {31'b0, fd_valid}, 32'd0);
        chk("reset_busy", {31'b0, slave_busy}, 32'd0);
        chk("reset_err", {24'b0, err_cnt}, 32'd0);
        chk("reset_out", fd_out, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        step();

        // Line write then read-back through a different in-line address.
        for (int v = 0; v < 4; v++) begin
            do_write(vt[v].addr, vt[v].d, int'(vt[v].gap));
            for (int i = 0; i < 4; i++) mem_m[vt[v].base[5:0] | 6'(i)] = vt[v].d[i];
            do_read(vt[v].base | 8'h03, vt[v].base[5:0], 0);
        end
        do_read(8'h08, 6'h08, 0);

        // Strobes without the bus are ignored silently.
        master  = 1'b0;
        writefd = 1'b1;
        addrfd  = 1'b1;
        step();
        writefd = 1'b0;
        addrfd  = 1'b0;
        master  = 1'b1;
        step();
        chk("no_master_ignored", {24'b0, err_cnt}, exp_err);

        // WRITEFD with no valid address.
        writefd = 1'b1;
        fd_in   = 32'h0000BEEF;
        step();
        writefd = 1'b0;
        fd_in   = 32'd0;
        bump_err();
        chk("wr_no_addr_err", {24'b0, err_cnt}, exp_err);
        chk("wr_no_addr_idle", {31'b0, slave_busy}, 32'd0);
        do_read(8'h08, 6'h08, 0);

        // Partial write aborted by losing the bus leaves the line untouched.
        addrfd = 1'b1;
        fd_in  = 32'h00000020;
        step();
        addrfd = 1'b0;
        for (int b = 0; b < 2; b++) begin
            writefd = 1'b1;
            fd_in   = 32'h0000DEAD;
            step();
        end
        writefd = 1'b0;
        fd_in   = 32'd0;
        master  = 1'b0;
        step();
        master  = 1'b1;
        bump_err();
        chk("wr_abort_err", {24'b0, err_cnt}, exp_err);
        do_read(8'h20, 6'h20, 0);

        // Master drops during the second read beat.
        do_read(8'h3C, 6'h3C, int'(RD_LAT) + 2);

        // ADDRFD and READFD together.
        addrfd = 1'b1;
        readfd = 1'b1;
        fd_in  = 32'h00000008;
        step();
        addrfd = 1'b0;
        readfd = 1'b0;
        fd_in  = 32'd0;
        bump_err();
        chk("dual_strobe_err", {24'b0, err_cnt}, exp_err);
        chk("dual_strobe_busy", {31'b0, slave_busy}, 32'd0);
        step();
        chk("dual_strobe_no_read", {31'b0, slave_busy}, 32'd0);

        // Reset lands on the commit edge: no write, counter cleared.
        addrfd = 1'b1;
        fd_in  = 32'h00000010;
        step();
        addrfd = 1'b0;
        for (int b = 0; b < 4; b++) begin
            writefd = 1'b1;
            fd_in   = 32'h00009990 + 32'(b);
            step();
        end
        writefd = 1'b0;
        fd_in   = 32'd0;
        chk("commit_busy", {31'b0, slave_busy}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_err = 0;
        chk("rst_commit_busy", {31'b0, slave_busy}, 32'd0);
        chk("rst_commit_err", {24'b0, err_cnt}, 32'd0);
        do_read(8'h10, 6'h10, 0);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            writefd = 1'b1;
            readfd  = 1'b1;
            step();
            bump_err();
        end
        writefd = 1'b0;
        readfd  = 1'b0;
        step();
        chk("err_saturate", {24'b0, err_cnt}, exp_err);
        chk("err_saturate_255", {24'b0, err_cnt}, 32'd255);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
